// File: rtl/mem_cmd_sequencer_if.sv
// rtl/mem_cmd_sequencer_if.sv - producer, completion and memory-port bundle for mem_cmd_sequencer
interface mem_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_wr;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;

    logic                   rsp_valid;
    logic                   rsp_is_wr;
    logic                   rsp_err;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    logic [COUNT_WIDTH-1:0] count;

    logic                   mem_wr;
    logic                   mem_rd;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem_response;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_response,
        output req_ready, rsp_valid, rsp_is_wr, rsp_err, rsp_rdata, count,
               mem_wr, mem_rd, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_response,
        input  req_ready, rsp_valid, rsp_is_wr, rsp_err, rsp_rdata, count,
               mem_wr, mem_rd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// rtl/mem_cmd_sequencer.sv - command FIFO that issues one memory op at a time with per-command timeout
module mem_cmd_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_cmd_sequencer_if.slave bus
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam int TCNT_WIDTH  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_next;

    logic                   fifo_wr    [DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_addr  [DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_wdata [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] occupancy;
    logic [TCNT_WIDTH-1:0]  tcnt;

    logic                   full;
    logic                   push;
    logic                   done;
    logic                   resp_ok;
    logic                   head_wr;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_wdata;

    logic                   rsp_valid_q;
    logic                   rsp_is_wr_q;
    logic                   rsp_err_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;

    assign full       = (occupancy == COUNT_WIDTH'(DEPTH));
    assign push       = bus.req_valid && !full;
    assign resp_ok    = (state == WAIT) && bus.mem_response;
    assign done       = (state == WAIT) && (bus.mem_response || tcnt == TCNT_WIDTH'(TIMEOUT));
    assign head_wr    = fifo_wr[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_wdata[rd_ptr];

    assign bus.req_ready = !full;
    assign bus.count     = occupancy;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_is_wr = rsp_is_wr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]    <= bus.req_wr;
            fifo_addr[wr_ptr]  <= bus.req_addr;
            fifo_wdata[wr_ptr] <= bus.req_wdata;
        end
    end

    // The head stays counted until its completion, so pop coincides with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (done) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({push, done})
                2'b10:   occupancy <= occupancy + COUNT_WIDTH'(1);
                2'b01:   occupancy <= occupancy - COUNT_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (occupancy != '0) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_wr    = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            ISSUE: begin
                bus.mem_wr    = head_wr;
                bus.mem_rd    = !head_wr;
                bus.mem_addr  = head_addr;
                bus.mem_wdata = head_wdata;
            end
            WAIT: begin
                bus.mem_addr  = head_addr;
                bus.mem_wdata = head_wdata;
            end
            default: ;
        endcase
    end

    // Counter is 0 during ISSUE and 1 in the first WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              tcnt <= '0;
        else if (state == IDLE)  tcnt <= '0;
        else                     tcnt <= tcnt + TCNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_is_wr_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done;
            rsp_is_wr_q <= done && head_wr;
            rsp_err_q   <= done && !bus.mem_response;
            rsp_rdata_q <= (resp_ok && !head_wr) ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// tb/tb_mem_cmd_sequencer.sv - randomized self-checking bench for mem_cmd_sequencer
module tb_mem_cmd_sequencer;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mem_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    mem_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cmd_t          pend_q[$];
    int            pcyc_q[$];
    cmd_t          offer_q[$];
    int            plan_q[$];
    logic [DW-1:0] mem_arr [16];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit busy = 0;
    int widx = 0;
    int plan_d = 0;
    int exp_rsp_cyc = 0;
    int last_rsp_cyc = -100;
    logic exp_is_wr, exp_err;
    logic [DW-1:0] exp_rdata;
    bit rand_push = 0;
    bit rand_spur = 0;

    int n_rsp = 0, n_err = 0, n_wr = 0, n_rd = 0, n_acc = 0;
    int obs_iss_cyc = 0, obs_rsp_cyc = 0;
    logic obs_is_wr, obs_err;
    logic [DW-1:0] obs_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr    = 1'($urandom_range(0, 1));
        c.addr  = AW'($urandom_range(0, 15));
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic int rand_plan();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)  return -1;
        if (r == 2) return TIMEOUT;
        if (r == 3) return TIMEOUT - 1;
        return $urandom_range(1, 4);
    endfunction

    function automatic cmd_t mk(input logic wr, input int addr, input logic [DW-1:0] wdata);
        cmd_t c;
        c.wr = wr;
        c.addr = AW'(addr);
        c.wdata = wdata;
        return c;
    endfunction

    // One clock: observe at the falling edge, step the model, drive inputs for the next rising edge.
    task automatic tick();
        bit issued;
        int exp_iss;
        cmd_t c;
        issued = 0;
        @(negedge clk);
        cyc++;
        if (bus.mem_wr) n_wr++;
        if (bus.mem_rd) n_rd++;
        if (bus.mem_wr || bus.mem_rd) obs_iss_cyc = cyc;
        if (bus.rsp_valid) begin
            n_rsp++;
            if (bus.rsp_err) n_err++;
            obs_rsp_cyc = cyc;
            obs_is_wr = bus.rsp_is_wr;
            obs_err = bus.rsp_err;
            obs_rdata = bus.rsp_rdata;
        end

        if (busy && cyc == exp_rsp_cyc) begin
            check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("rsp_is_wr", 64'(bus.rsp_is_wr), 64'(exp_is_wr));
            check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
            void'(pend_q.pop_front());
            void'(pcyc_q.pop_front());
            busy = 0;
            last_rsp_cyc = cyc;
        end else begin
            check("rsp_quiet", 64'({bus.rsp_valid, bus.rsp_is_wr, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        end

        check("count", 64'(bus.count), 64'(pend_q.size()));
        check("req_ready", 64'(bus.req_ready), 64'(pend_q.size() < DEPTH));

        exp_iss = -1;
        if (!busy && pend_q.size() != 0)
            exp_iss = (last_rsp_cyc + 1 > pcyc_q[0] + 2) ? last_rsp_cyc + 1 : pcyc_q[0] + 2;
        if (cyc == exp_iss) begin
            check("issue_strobe", 64'({bus.mem_wr, bus.mem_rd}), 64'({pend_q[0].wr, !pend_q[0].wr}));
            check("issue_addr", 64'(bus.mem_addr), 64'(pend_q[0].addr));
            if (pend_q[0].wr) check("issue_wdata", 64'(bus.mem_wdata), 64'(pend_q[0].wdata));
            busy = 1;
            issued = 1;
            widx = 0;
            plan_d = (plan_q.size() != 0) ? plan_q.pop_front() : rand_plan();
            exp_is_wr = pend_q[0].wr;
            if (plan_d > 0) begin
                exp_rsp_cyc = cyc + plan_d + 1;
                exp_err = 1'b0;
                exp_rdata = pend_q[0].wr ? '0 : mem_arr[pend_q[0].addr];
            end else begin
                exp_rsp_cyc = cyc + TIMEOUT + 1;
                exp_err = 1'b1;
                exp_rdata = '0;
            end
        end else begin
            check("no_strobe", 64'({bus.mem_wr, bus.mem_rd}), 64'd0);
            if (busy) check("wait_addr", 64'(bus.mem_addr), 64'(pend_q[0].addr));
        end

        bus.mem_response = 1'b0;
        bus.mem_rdata = $urandom;
        if (busy && !issued) begin
            widx++;
            if (widx == plan_d) begin
                bus.mem_response = 1'b1;
                if (pend_q[0].wr) mem_arr[pend_q[0].addr] = pend_q[0].wdata;
                else              bus.mem_rdata = mem_arr[pend_q[0].addr];
            end
        end else if (rand_spur && $urandom_range(0, 7) == 0) begin
            bus.mem_response = 1'b1;
        end

        bus.req_valid = 1'b0;
        c = rand_cmd();
        if (offer_q.size() != 0) begin
            c = offer_q[0];
            bus.req_valid = 1'b1;
        end else if (rand_push && $urandom_range(0, 1) == 1) begin
            bus.req_valid = 1'b1;
        end
        bus.req_wr = c.wr;
        bus.req_addr = c.addr;
        bus.req_wdata = c.wdata;
        if (bus.req_valid && pend_q.size() < DEPTH) begin
            pend_q.push_back(c);
            pcyc_q.push_back(cyc);
            n_acc++;
            if (offer_q.size() != 0) void'(offer_q.pop_front());
        end
    endtask

    task automatic clear_model();
        pend_q.delete();
        pcyc_q.delete();
        offer_q.delete();
        plan_q.delete();
        busy = 0;
        widx = 0;
        last_rsp_cyc = cyc - 100;
    endtask

    initial begin
        int base_rsp, base_err, base_wr, base_rd, base_acc, lat;
        for (int i = 0; i < 16; i++) mem_arr[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_response = 1'b0;

        @(negedge clk);
        check("reset_ready", 64'(bus.req_ready), 64'd1);
        check("reset_outs", 64'({bus.rsp_valid, bus.count, bus.mem_wr, bus.mem_rd, bus.mem_addr}), 64'd0);
        reset = 1'b1;

        base_rsp = n_rsp; base_wr = n_wr;
        offer_q.push_back(mk(1'b1, 3, 32'hDEADBEEF));
        plan_q.push_back(2);
        repeat (10) tick();
        check("t1_rsp_count", 64'(n_rsp - base_rsp), 64'd1);
        check("t1_wr_pulses", 64'(n_wr - base_wr), 64'd1);
        check("t1_rsp_fields", 64'({obs_is_wr, obs_err, obs_rdata}), {31'd0, 1'b1, 1'b0, 32'd0});

        base_rsp = n_rsp; base_rd = n_rd;
        offer_q.push_back(mk(1'b0, 3, 32'h0));
        plan_q.push_back(1);
        repeat (10) tick();
        check("t2_rd_pulses", 64'(n_rd - base_rd), 64'd1);
        check("t2_rdata", 64'({obs_is_wr, obs_err, obs_rdata}), 64'h0_DEADBEEF);

        base_rsp = n_rsp; base_err = n_err;
        for (int i = 0; i < 5; i++) begin
            offer_q.push_back(rand_cmd());
            plan_q.push_back(-1);
        end
        repeat (6) tick();
        check("t3_count_full", 64'(bus.count), 64'd4);
        check("t3_ready_low", 64'(bus.req_ready), 64'd0);
        repeat (130) tick();
        check("t3_rsp_count", 64'(n_rsp - base_rsp), 64'd5);
        check("t3_err_count", 64'(n_err - base_err), 64'd5);

        base_rsp = n_rsp;
        offer_q.push_back(mk(1'b0, 7, 32'h0));
        plan_q.push_back(-1);
        repeat (25) tick();
        lat = obs_rsp_cyc - obs_iss_cyc;
        check("t4_timeout_latency", 64'(lat), 64'(TIMEOUT + 1));
        check("t4_rsp_fields", 64'({obs_err, obs_rdata}), 64'h1_00000000);
        offer_q.push_back(mk(1'b1, 9, 32'h1234_5678));
        plan_q.push_back(1);
        repeat (10) tick();
        check("t4_next_cmd", 64'(n_rsp - base_rsp), 64'd2);
        check("t4_next_latency", 64'(obs_rsp_cyc - obs_iss_cyc), 64'd2);

        for (int i = 0; i < 4; i++) begin
            offer_q.push_back(rand_cmd());
            plan_q.push_back(-1);
        end
        for (int i = 0; i < 30 && !(busy && widx >= 1 && pend_q.size() == 4); i++) tick();
        check("t5_in_wait_full", 64'(busy && widx >= 1 && pend_q.size() == 4), 64'd1);
        bus.req_valid = 1'b0;
        bus.mem_response = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t5_async_outs", 64'({bus.rsp_valid, bus.count, bus.mem_wr, bus.mem_rd, bus.mem_addr}), 64'd0);
        check("t5_async_ready", 64'(bus.req_ready), 64'd1);
        check("t5_async_wdata", 64'(bus.mem_wdata), 64'd0);
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        base_rsp = n_rsp;
        repeat (20) tick();
        check("t5_no_rsp_after", 64'(n_rsp - base_rsp), 64'd0);
        offer_q.push_back(mk(1'b1, 5, 32'hCAFE_F00D));
        plan_q.push_back(2);
        repeat (10) tick();
        check("t5_new_cmd", 64'(n_rsp - base_rsp), 64'd1);

        base_rsp = n_rsp;
        rand_spur = 1;
        repeat (30) tick();
        check("t6_spurious", 64'(n_rsp - base_rsp), 64'd0);
        check("t6_count", 64'(bus.count), 64'd0);

        base_rsp = n_rsp; base_acc = n_acc;
        rand_push = 1;
        repeat (1500) tick();
        rand_push = 0;
        repeat (200) tick();
        check("rand_drained", 64'(bus.count), 64'd0);
        check("rand_rsp_total", 64'(n_rsp - base_rsp), 64'(n_acc - base_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
